// File: rtl/gestor_eventos.sv
// gestor_eventos
//   Sits between the debounce/toggle stage and the pet state machine. Each
//   toggle-per-event input is synchronised and edge-detected into a one-shot
//   event. Events are queued as one pending bit per source, arbitrated by
//   fixed priority, and handed to the state machine one at a time over a
//   valid/ack handshake. The block also owns the test-mode flag.
//
// Ports
//   clk           system clock, posedge
//   reset         asynchronous active-low reset
//   tog_test      toggles once per debounced test press
//   tog_energia   toggles once per energia press
//   tog_medicina  toggles once per medicina press
//   tog_fot       toggles once per photocell event
//   tog_ult       toggles once per ultrasonic event
//   cmd_ack       state machine accepts the current command
//   cmd_valid     command presented
//   cmd_code      1=TEST 2=MEDICINA 3=ENERGIA 4=FOT 5=ULT, 0=none
//   test_mode     test mode active
//   busy          any pending bit set or FSM not idle
//   overflow_err  sticky: event arrived while its source was already pending
//   timeout_err   sticky: a command was dropped on timeout
module gestor_eventos #(
  parameter int unsigned N_TIMEOUT = 16,
  parameter int unsigned N_PRIME   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tog_test,
  input  logic       tog_energia,
  input  logic       tog_medicina,
  input  logic       tog_fot,
  input  logic       tog_ult,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       test_mode,
  output logic       busy,
  output logic       overflow_err,
  output logic       timeout_err
);

  localparam int unsigned PW = (N_PRIME < 1) ? 1 : $clog2(N_PRIME + 1);
  localparam int unsigned TW = $clog2(N_TIMEOUT);
  localparam logic [PW-1:0] PRIME_END = PW'(N_PRIME);
  localparam logic [TW-1:0] TMAX      = TW'(N_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bit order: test, medicina, energia, fot, ult (bit 4 has highest priority).
  logic [4:0]    tog_w;
  logic [4:0]    sync1_q, sync2_q, prev_q;
  logic [4:0]    pend_q, pend_d;
  logic [4:0]    evt, clr;
  logic [PW-1:0] prime_q, prime_d;
  logic          priming;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    code_q, code_d, win_code;
  logic          test_mode_q, test_mode_d;
  logic          ovf_q, ovf_d;
  logic          tmo_err_q, tmo_err_d;
  logic          xfer, tmo;
  state_t        state_q, state_d;

  assign tog_w = {tog_test, tog_medicina, tog_energia, tog_fot, tog_ult};

  // prev always tracks sync2, so changes seen during priming are absorbed.
  assign priming = (prime_q < PRIME_END);
  assign prime_d = priming ? prime_q + 1'b1 : prime_q;

  // fot/ult events are dropped outright in test mode: never pended, never overflow.
  assign evt = (sync2_q ^ prev_q)
             & {5{~priming}}
             & {3'b111, {2{~test_mode_q}}};

  always_comb begin : arbiter
    win_code = 3'd0;
    if      (pend_q[4]) win_code = 3'd1;
    else if (pend_q[3]) win_code = 3'd2;
    else if (pend_q[2]) win_code = 3'd3;
    else if (pend_q[1]) win_code = 3'd4;
    else if (pend_q[0]) win_code = 3'd5;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin : next_state
    state_d = state_q;
    code_d  = code_q;
    tcnt_d  = tcnt_q;
    xfer    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = ISSUE;
          code_d  = win_code;
          tcnt_d  = '0;
        end
      end
      ISSUE: begin
        if (cmd_ack) begin
          xfer    = 1'b1;
          state_d = GAP;
          code_d  = '0;
        end else if (tcnt_q == TMAX) begin
          tmo     = 1'b1;
          state_d = GAP;
          code_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin : outputs
    cmd_valid    = (state_q == ISSUE);
    cmd_code     = (state_q == ISSUE) ? code_q : 3'd0;
    busy         = (|pend_q) || (state_q != IDLE);
    test_mode    = test_mode_q;
    overflow_err = ovf_q;
    timeout_err  = tmo_err_q;
  end

  always_comb begin : pend_update
    clr = '0;
    if (xfer || tmo) begin
      case (code_q)
        3'd1:    clr = 5'b10000;
        3'd2:    clr = 5'b01000;
        3'd3:    clr = 5'b00100;
        3'd4:    clr = 5'b00010;
        3'd5:    clr = 5'b00001;
        default: clr = '0;
      endcase
    end
    // An event landing on the clearing edge re-sets the bit without overflow.
    pend_d      = (pend_q & ~clr) | evt;
    ovf_d       = ovf_q | (|(evt & pend_q & ~clr));
    tmo_err_d   = tmo_err_q | tmo;
    test_mode_d = (xfer && (code_q == 3'd1)) ? ~test_mode_q : test_mode_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      pend_q      <= '0;
      prime_q     <= '0;
      tcnt_q      <= '0;
      code_q      <= '0;
      test_mode_q <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      sync1_q     <= tog_w;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      pend_q      <= pend_d;
      prime_q     <= prime_d;
      tcnt_q      <= tcnt_d;
      code_q      <= code_d;
      test_mode_q <= test_mode_d;
      ovf_q       <= ovf_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

endmodule

// File: tb/tb_gestor_eventos.sv
module tb_gestor_eventos;

  logic       clk = 1'b0;
  logic       reset;
  logic       tog_test, tog_energia, tog_medicina, tog_fot, tog_ult;
  logic       cmd_ack;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       test_mode, busy, overflow_err, timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gestor_eventos #(
    .N_TIMEOUT(16),
    .N_PRIME  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tog_test    (tog_test),
    .tog_energia (tog_energia),
    .tog_medicina(tog_medicina),
    .tog_fot     (tog_fot),
    .tog_ult     (tog_ult),
    .cmd_ack     (cmd_ack),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .test_mode   (test_mode),
    .busy        (busy),
    .overflow_err(overflow_err),
    .timeout_err (timeout_err)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Waits on falling edges until cmd_valid; lat = edges waited (budget+1 if never).
  task automatic wait_valid(input int budget, output int lat);
    lat = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cmd_valid) cnt++;
    end
  endtask

  task automatic pulse_ack();
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b0;
    tog_test = 1'b1; tog_energia = 1'b1; tog_medicina = 1'b1;
    tog_fot = 1'b1;  tog_ult = 1'b1;     cmd_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_code, test_mode, busy, overflow_err, timeout_err} !== 8'h00) begin
      errors++;
      $display("FAIL rst_outputs: got %b expected 00000000",
               {cmd_valid, cmd_code, test_mode, busy, overflow_err, timeout_err});
    end
    reset = 1'b1;
    count_valid(20, cnt);
    checks++;
    if (cnt !== 0) begin
      errors++; $display("FAIL prime_no_cmd: got %0d valid cycles expected 0", cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL prime_busy: got %b expected 0", busy);
    end
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++; $display("FAIL prime_ovf: got %b expected 0", overflow_err);
    end
  endtask

  task automatic test_single();
    int lat;
    cmd_ack = 1'b1;
    tog_medicina = ~tog_medicina;
    wait_valid(12, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL single_latency: got %0d expected 4", lat);
    end
    checks++;
    if (cmd_code !== 3'd2) begin
      errors++; $display("FAIL single_code: got %0d expected 2", cmd_code);
    end
    @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_code} !== 4'b0000) begin
      errors++; $display("FAIL single_gap: got valid=%b code=%0d expected 0/0", cmd_valid, cmd_code);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single_busy_gap: got %b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_idle: got %b expected 0", busy);
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_two_sources();
    int lat;
    tog_ult = ~tog_ult;
    tog_energia = ~tog_energia;
    wait_valid(12, lat);
    checks++;
    if (lat !== 4 || cmd_code !== 3'd3) begin
      errors++; $display("FAIL two_first: got lat=%0d code=%0d expected 4/3", lat, cmd_code);
    end
    @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_code} !== 4'b1011) begin
      errors++; $display("FAIL two_stable: got valid=%b code=%0d expected 1/3", cmd_valid, cmd_code);
    end
    pulse_ack();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL two_drop: got %b expected 0", cmd_valid);
    end
    wait_valid(12, lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL two_spacing: got %0d low cycles expected 2", lat);
    end
    checks++;
    if (cmd_code !== 3'd5) begin
      errors++; $display("FAIL two_second: got %0d expected 5", cmd_code);
    end
    @(negedge clk);
    pulse_ack();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL two_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_test_mode();
    int lat, cnt;
    tog_test = ~tog_test;
    wait_valid(12, lat);
    checks++;
    if (lat !== 4 || cmd_code !== 3'd1 || test_mode !== 1'b0) begin
      errors++;
      $display("FAIL tm_issue: got lat=%0d code=%0d tm=%b expected 4/1/0", lat, cmd_code, test_mode);
    end
    pulse_ack();
    checks++;
    if (test_mode !== 1'b1) begin
      errors++; $display("FAIL tm_on: got %b expected 1", test_mode);
    end
    tog_fot = ~tog_fot;
    count_valid(12, cnt);
    checks++;
    if (cnt !== 0 || overflow_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tm_fot_drop: got valid=%0d ovf=%b busy=%b expected 0/0/0", cnt, overflow_err, busy);
    end
    tog_test = ~tog_test;
    wait_valid(12, lat);
    checks++;
    if (lat !== 4 || cmd_code !== 3'd1) begin
      errors++; $display("FAIL tm_issue2: got lat=%0d code=%0d expected 4/1", lat, cmd_code);
    end
    pulse_ack();
    checks++;
    if (test_mode !== 1'b0) begin
      errors++; $display("FAIL tm_off: got %b expected 0", test_mode);
    end
    @(negedge clk);
  endtask

  // Second medicina event lands on the same edge its pending bit is cleared.
  task automatic test_back_to_back();
    int lat;
    tog_medicina = ~tog_medicina;
    wait_valid(12, lat);
    checks++;
    if (lat !== 4 || cmd_code !== 3'd2) begin
      errors++; $display("FAIL b2b_first: got lat=%0d code=%0d expected 4/2", lat, cmd_code);
    end
    tog_medicina = ~tog_medicina;
    @(negedge clk);
    @(negedge clk);
    pulse_ack();
    checks++;
    if (cmd_valid !== 1'b0 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: got valid=%b ovf=%b expected 0/0", cmd_valid, overflow_err);
    end
    wait_valid(12, lat);
    checks++;
    if (lat !== 2 || cmd_code !== 3'd2) begin
      errors++; $display("FAIL b2b_second: got lat=%0d code=%0d expected 2/2", lat, cmd_code);
    end
    pulse_ack();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, n;
    logic code_bad;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_pre: got %b expected 0", timeout_err);
    end
    tog_energia = ~tog_energia;
    wait_valid(12, lat);
    code_bad = (cmd_code !== 3'd3);
    n = (lat == 4) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cmd_valid) break;
      n++;
      if (cmd_code !== 3'd3) code_bad = 1'b1;
    end
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL to_length: got %0d valid cycles expected 16", n);
    end
    checks++;
    if (code_bad !== 1'b0) begin
      errors++; $display("FAIL to_code_stable: got unstable=%b expected 0", code_bad);
    end
    checks++;
    if (timeout_err !== 1'b1 || test_mode !== 1'b0) begin
      errors++; $display("FAIL to_flags: got to=%b tm=%b expected 1/0", timeout_err, test_mode);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL to_pend_clr: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_overflow_reset();
    int lat, cnt;
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++; $display("FAIL ovf_pre: got %b expected 0", overflow_err);
    end
    tog_medicina = ~tog_medicina;
    repeat (5) @(negedge clk);
    tog_medicina = ~tog_medicina;
    repeat (3) @(negedge clk);
    checks++;
    if (overflow_err !== 1'b1 || cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b valid=%b code=%0d expected 1/1/2", overflow_err, cmd_valid, cmd_code);
    end
    pulse_ack();
    count_valid(12, cnt);
    checks++;
    if (cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_single_cmd: got extra=%0d busy=%b expected 0/0", cnt, busy);
    end
    tog_energia = ~tog_energia;
    wait_valid(12, lat);
    checks++;
    if (lat !== 4 || cmd_code !== 3'd3) begin
      errors++; $display("FAIL rstmid_issue: got lat=%0d code=%0d expected 4/3", lat, cmd_code);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, cmd_code, test_mode, busy, overflow_err, timeout_err} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: got %b expected 00000000",
               {cmd_valid, cmd_code, test_mode, busy, overflow_err, timeout_err});
    end
    @(negedge clk);
    reset = 1'b1;
    count_valid(12, cnt);
    checks++;
    if (cnt !== 0) begin
      errors++; $display("FAIL rstmid_lost: got %0d valid cycles expected 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_sources();
    test_test_mode();
    test_back_to_back();
    test_timeout();
    test_overflow_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gestor_eventos.md
Name: gestor_eventos

Overview:
- Controller between the debounce/toggle stage and the pet state machine.
- Inputs are toggle-per-event signals from the debounced buttons (test, energia, medicina) and sensors (ultrasonido, fotocelda).
- Converts each toggle into a one-shot event, queues one pending event per source, and arbitrates them by fixed priority.
- Delivers one command at a time to the state machine over a valid/ack handshake. Also owns the test-mode flag.

Parameters:
- N_TIMEOUT, 16, cycles cmd_valid may wait for cmd_ack before the command is dropped (range 2..255).
- N_PRIME, 3, cycles after reset release during which input changes are absorbed, not reported.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- tog_test  input  1  toggles once per debounced test press.
- tog_energia  input  1  toggles once per energia press.
- tog_medicina  input  1  toggles once per medicina press.
- tog_fot  input  1  toggles once per photocell event.
- tog_ult  input  1  toggles once per ultrasonic event.
- cmd_ack  input  1  state machine accepts the current command.
- cmd_valid  output  1  command presented.
- cmd_code  output  3  1=TEST, 2=MEDICINA, 3=ENERGIA, 4=FOT, 5=ULT, 0=none.
- test_mode  output  1  test mode active.
- busy  output  1  any pending bit set, or FSM not IDLE.
- overflow_err  output  1  sticky: an event arrived while its source was already pending.
- timeout_err  output  1  sticky: a command was dropped on timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Pending bits, sync registers, previous-value registers, the timeout counter and the prime counter all clear.
  - Sticky errors clear only on reset.
  - A reset mid-handshake drops cmd_valid immediately and loses the command.
- Input path, per source:
  - 2-FF synchroniser, then a prev register.
  - event = sync2 XOR prev.
  - Latency from an input toggle to the pending bit being set is 3 clk edges.
- Priming:
  - For the first N_PRIME cycles after reset release, prev follows sync2 and events are discarded.
  - A toggle input held high across reset therefore produces no event.
- Pending bits pend[4:0] (test, medicina, energia, fot, ult):
  - An event sets its bit.
  - An event on an already-set bit sets overflow_err and the event is lost (no count).
  - An event in the same cycle its bit is being cleared by a transfer keeps the bit set, with no overflow.
- While test_mode=1, fot and ult events are discarded. They are not pended and do not set overflow_err.
- Arbitration in IDLE: fixed priority test > medicina > energia > fot > ult. The winner is latched into cmd_code.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if any pend bit is set, go to ISSUE next cycle with cmd_valid=1, cmd_code=winner, timeout counter=0. Otherwise stay.
  - ISSUE, cmd_ack=1 sampled: transfer in that cycle, the winner's pend bit clears, go to GAP.
    - If the code is TEST, test_mode toggles on the same edge.
  - ISSUE, cmd_ack=0: the counter increments. When the counter reaches N_TIMEOUT-1 without ack, the pend bit clears, timeout_err is set, and the FSM goes to GAP. test_mode is not toggled.
  - GAP: cmd_valid=0 for exactly one cycle, then IDLE.
- Handshake rules:
  - cmd_code and cmd_valid are stable while in ISSUE. A higher-priority event arriving during ISSUE waits.
  - Minimum spacing between transfers is 3 cycles (ISSUE, GAP, IDLE).
  - cmd_ack outside ISSUE is ignored.
- cmd_code returns to 0 in GAP/IDLE.
- busy is combinational from registered state.

Test Plan:
- Reset with all tog_*=1, release, hold 20 cycles -> no cmd_valid, pend=0, busy=0.
- Toggle tog_medicina once at cycle 10; ack tied high -> cmd_valid high for one cycle with cmd_code=2; GAP follows, then IDLE; busy returns to 0.
- Toggle tog_ult and tog_energia in the same cycle; ack after 2 cycles each -> energia (3) issued first, ult (5) second, with a gap of at least 1 idle cycle between the cmd_valid pulses.
- Toggle tog_test, ack -> test_mode=1. Then toggle tog_fot -> no command, no overflow. Toggle tog_test again -> test_mode=0.
- Hold cmd_ack=0 with N_TIMEOUT=16 and toggle tog_energia -> cmd_valid high for exactly 16 cycles; timeout_err=1; pend cleared; test_mode unchanged.
- Toggle tog_medicina twice (5 cycles apart) while ack=0 -> overflow_err=1 and only one medicina command issued. Assert reset mid-ISSUE -> cmd_valid=0 asynchronously and all errors cleared.
